// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// FSM state encodings and the shift-and-add-3 digit constants.
package bin_to_bcd_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CONVERT = 2'd1,
      ST_DONE    = 2'd2
   } state_e;

   localparam int         BCD_DIGIT_W = 4;
   localparam logic [3:0] ADJ_THRESH  = 4'd5;
   localparam logic [3:0] ADJ_ADD     = 4'd3;
   localparam logic [3:0] BCD_NINE    = 4'h9;

endpackage : bin_to_bcd_seq_pkg

// File: rtl/bin_to_bcd_seq_if.sv
// Start/busy/done handshake and result bus of the binary-to-BCD converter.
// The requester (master) drives Start/Value; the converter (slave) answers.
interface bin_to_bcd_seq_if #(
   parameter int WIDTH  = 32,
   parameter int DIGITS = 4
);
   logic                  Start;
   logic [WIDTH-1:0]      Value;
   logic                  Busy;
   logic                  Done;
   logic [DIGITS*4-1:0]   Bcd;
   logic                  Overflow;

   modport master (output Start, Value, input Busy, Done, Bcd, Overflow);
   modport slave  (input Start, Value, output Busy, Done, Bcd, Overflow);
endinterface : bin_to_bcd_seq_if

// File: rtl/bin_to_bcd_seq_bcd_digit_adj.sv
// One BCD digit of the shift-and-add-3 step: a digit of 5 or more gets +3
// so that the following left shift carries correctly into the next digit.
module bcd_digit_adj
   import bin_to_bcd_seq_pkg::*;
(
   input  logic [3:0] digit_i,
   output logic [3:0] digit_o
);
   assign digit_o = (digit_i >= ADJ_THRESH) ? digit_i + ADJ_ADD : digit_i;
endmodule : bcd_digit_adj

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter, one input bit per clock.
// Results are held in output registers that only change on completion, so a
// downstream display never shows a partially converted number.
module bin_to_bcd_seq
   import bin_to_bcd_seq_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int DIGITS = 4
) (
   input logic             Clk,
   input logic             Rst,
   bin_to_bcd_seq_if.slave bus
);
   localparam int               BCD_W     = DIGITS * BCD_DIGIT_W;
   localparam int               CNT_W     = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(WIDTH - 1);
   localparam logic [BCD_W-1:0] ALL_NINES = {DIGITS{BCD_NINE}};

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [BCD_W-1:0] scratch_q, scratch_d;
   logic [BCD_W-1:0] scratch_adj;
   logic             ovf_q, ovf_d;
   logic [BCD_W-1:0] bcd_q, bcd_d;
   logic             overflow_q, overflow_d;

   for (genvar g = 0; g < DIGITS; g++) begin : g_adj
      bcd_digit_adj u_adj (
         .digit_i (scratch_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
         .digit_o (scratch_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
      );
   end

   // Next-state, datapath and result-load decode.
   always_comb begin
      // NOTE: every variable gets its hold value first so no path leaves one
      // unassigned, which would otherwise infer a latch.
      state_d    = state_q;
      cnt_d      = cnt_q;
      shift_d    = shift_q;
      scratch_d  = scratch_q;
      ovf_d      = ovf_q;
      bcd_d      = bcd_q;
      overflow_d = overflow_q;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (bus.Start) begin
               state_d   = ST_CONVERT;
               shift_d   = bus.Value;
               scratch_d = '0;
               ovf_d     = 1'b0;
               cnt_d     = CNT_LAST;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_CONVERT: begin
            // Top digit >= 5 means the next shift pushes a carry out of range.
            ovf_d = ovf_q | (scratch_q[BCD_W-1 -: BCD_DIGIT_W] >= ADJ_THRESH);
            {scratch_d, shift_d} = {scratch_adj, shift_q} << 1;
            if (cnt_q == '0) begin
               state_d    = ST_DONE;
               overflow_d = ovf_d;
               bcd_d      = ovf_d ? ALL_NINES : scratch_d;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge Clk) begin
      if (!Rst) begin
         // NOTE: the working registers are reset along with the outputs;
         // they are few and a known value keeps reset-abort behaviour clean.
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         shift_q    <= '0;
         scratch_q  <= '0;
         ovf_q      <= 1'b0;
         bcd_q      <= '0;
         overflow_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values regardless of statement order.
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         shift_q    <= shift_d;
         scratch_q  <= scratch_d;
         ovf_q      <= ovf_d;
         bcd_q      <= bcd_d;
         overflow_q <= overflow_d;
      end
   end

   assign bus.Busy     = (state_q == ST_CONVERT);
   assign bus.Done     = (state_q == ST_DONE);
   assign bus.Bcd      = bcd_q;
   assign bus.Overflow = overflow_q;

endmodule : bin_to_bcd_seq
